// File: rtl/systolic_skew_feeder_if.sv
// Operand/handshake bundle between the capture stage, the skew feeder and the PE grid.
// The slave modport is the feeder's view; master is the driver/consumer side.
interface systolic_skew_feeder_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  logic [N-1:0][N-1:0][W-1:0] i_a;
  logic [N-1:0][N-1:0][W-1:0] i_b;
  logic                       i_start;
  logic                       o_busy;
  logic                       o_clearAcc;
  logic                       o_feedValid;
  logic [N-1:0][W-1:0]        o_rowA;
  logic [N-1:0][W-1:0]        o_colB;
  logic                       o_done;

  modport slave (
    input  i_a, i_b, i_start,
    output o_busy, o_clearAcc, o_feedValid, o_rowA, o_colB, o_done
  );

  modport master (
    output i_a, i_b, i_start,
    input  o_busy, o_clearAcc, o_feedValid, o_rowA, o_colB, o_done
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Diagonally skewed A-row / B-column feeder for an NxN PE grid: clear, feed, drain, done.
// SKEW_FEEDER_DRAIN_EN enables the N-1 cycle zero-operand DRAIN phase before o_done.
module systolic_skew_feeder #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input logic                    i_clk,
  input logic                    i_arst,
  systolic_skew_feeder_if.slave  bus
);
  localparam int unsigned TW = $clog2(2 * N - 1);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  // Counter runs one step past the last feed step so that step registers before leaving FEED.
  localparam logic [TW-1:0] T_SPILL = TW'(2 * N - 1);
`ifdef SKEW_FEEDER_DRAIN_EN
  localparam logic [TW-1:0] T_DRAIN_LAST = TW'(N - 2);
`endif

  typedef logic [N-1:0][N-1:0][W-1:0] mat_t;
  typedef logic [N-1:0][W-1:0]        lane_t;
  typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_DRAIN, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  mat_t            a_q, a_d;
  mat_t            b_q, b_d;
  lane_t           row_q, row_d;
  lane_t           col_q, col_d;
  logic            busy_q, busy_d;
  logic            clear_q, clear_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;

  // Next state, counter, operand capture and skewed lane selection.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;
    row_d   = '0;
    col_d   = '0;
    clear_d = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          a_d     = bus.i_a;
          b_d     = bus.i_b;
          t_d     = '0;
          state_d = ST_FEED;
        end
      end
      ST_FEED: begin
        valid_d = (t_q != T_SPILL);
        clear_d = (t_q == '0);
        if (valid_d) begin
          for (int l = 0; l < int'(N); l++) begin
            if ((int'(t_q) >= l) && ((int'(t_q) - l) < int'(N))) begin
              row_d[l] = a_q[l][IW'(int'(t_q) - l)];
              col_d[l] = b_q[IW'(int'(t_q) - l)][l];
            end
          end
        end
        t_d = t_q + TW'(1);
        if (t_q == T_SPILL) begin
          t_d = '0;
`ifdef SKEW_FEEDER_DRAIN_EN
          state_d = ST_DRAIN;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef SKEW_FEEDER_DRAIN_EN
      ST_DRAIN: begin
        t_d = t_q + TW'(1);
        if (t_q == T_DRAIN_LAST) begin
          t_d     = '0;
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      clear_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      a_q     <= a_d;
      b_q     <= b_d;
      row_q   <= row_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
      clear_q <= clear_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_busy      = busy_q;
  assign bus.o_clearAcc  = clear_q;
  assign bus.o_feedValid = valid_q;
  assign bus.o_rowA      = row_q;
  assign bus.o_colB      = col_q;
  assign bus.o_done      = done_q;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: directed and random matrix runs against a
// per-cycle reference built from the skew rule and the start-to-done latency.
module tb_systolic_skew_feeder;
  localparam int unsigned N = 4;
  localparam int unsigned W = 8;
  localparam int NI = 4;
`ifdef SKEW_FEEDER_DRAIN_EN
  localparam int LAT = 3 * NI - 1;
`else
  localparam int LAT = 2 * NI;
`endif

  typedef logic [N-1:0][N-1:0][W-1:0] mat_t;
  typedef logic [N-1:0][W-1:0]        lane_t;

  logic  clk = 1'b0;
  logic  arst;
  int    checks = 0;
  int    errors = 0;
  lane_t obs_row [0:15];
  lane_t obs_col [0:15];
  int    done_cnt;
  int    done_cyc;

  systolic_skew_feeder_if #(.N(N), .W(W)) bus ();
  systolic_skew_feeder #(.N(N), .W(W)) dut (.i_clk(clk), .i_arst(arst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".busy"},  64'(bus.o_busy),      64'd0);
    chk({tag, ".clear"}, 64'(bus.o_clearAcc),  64'd0);
    chk({tag, ".valid"}, 64'(bus.o_feedValid), 64'd0);
    chk({tag, ".done"},  64'(bus.o_done),      64'd0);
    chk({tag, ".rowA"},  64'(bus.o_rowA),      64'd0);
    chk({tag, ".colB"},  64'(bus.o_colB),      64'd0);
  endtask

  // Lane i at step t carries A[i][t-i]; lane j carries B[t-j][j]; zero outside the window.
  function automatic lane_t skew_a(input mat_t m, input int t);
    lane_t r = '0;
    for (int i = 0; i < NI; i++)
      if (t - i >= 0 && t - i < NI) r[i] = m[i][t - i];
    return r;
  endfunction

  function automatic lane_t skew_b(input mat_t m, input int t);
    lane_t r = '0;
    for (int j = 0; j < NI; j++)
      if (t - j >= 0 && t - j < NI) r[j] = m[t - j][j];
    return r;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < NI; i++)
      for (int k = 0; k < NI; k++) m[i][k] = W'($urandom);
    return m;
  endfunction

  // One start pulse, then every cycle up to one past o_done is compared to the reference.
  task automatic run(input mat_t a, input mat_t b, input int dup_step, input string tag);
    int t;
    bit feed;
    bus.i_a = a;
    bus.i_b = b;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    done_cnt = 0;
    done_cyc = -1;
    for (int c = 1; c <= LAT + 1; c++) begin
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      t = c - 1;
      feed = (t < 2 * NI - 1);
      obs_row[c] = bus.o_rowA;
      obs_col[c] = bus.o_colB;
      if (bus.o_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      chk({tag, ".rowA"},  64'(bus.o_rowA),      feed ? 64'(skew_a(a, t)) : 64'd0);
      chk({tag, ".colB"},  64'(bus.o_colB),      feed ? 64'(skew_b(b, t)) : 64'd0);
      chk({tag, ".valid"}, 64'(bus.o_feedValid), 64'(feed));
      chk({tag, ".clear"}, 64'(bus.o_clearAcc),  64'(c == 1));
      chk({tag, ".busy"},  64'(bus.o_busy),      64'(c <= LAT));
      chk({tag, ".done"},  64'(bus.o_done),      64'(c == LAT));
      if (c == dup_step + 1) begin
        bus.i_a = ~a;
        bus.i_b = ~b;
        bus.i_start = 1'b1;
      end
    end
    chk({tag, ".done_count"}, 64'(done_cnt), 64'd1);
    chk({tag, ".done_lat"},   64'(done_cyc), 64'(LAT));
  endtask

  initial begin
    mat_t a;
    mat_t b;
    int   gap;

    arst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_a = '0;
    bus.i_b = '0;
    #1;
    idle_chk("reset");
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      idle_chk("idle");
    end

    // Identity A against counting B.
    for (int i = 0; i < NI; i++)
      for (int k = 0; k < NI; k++) begin
        a[i][k] = (i == k) ? W'(1) : W'(0);
        b[i][k] = W'(4 * i + k + 1);
      end
    run(a, b, -1, "ident");
    chk("ident.t0_rowA", 64'(obs_row[1]), 64'h0000_0001);
    chk("ident.t0_colB", 64'(obs_col[1]), 64'h0000_0001);
    chk("ident.t3_rowA", 64'(obs_row[4]), 64'h0000_0000);
    chk("ident.t3_colB3", 64'(obs_col[4][3]), 64'd4);
    // The identity diagonal reaches lane i at step 2i.
    chk("ident.t6_rowA", 64'(obs_row[7]), 64'h0100_0000);

    // All-ones operands expose the exact nonzero window of every lane.
    a = '1;
    b = '1;
    run(a, b, -1, "window");
    for (int t = 0; t < LAT; t++)
      for (int i = 0; i < NI; i++) begin
        chk("window.rowA_lane", 64'(obs_row[t + 1][i] != '0), 64'(t >= i && t <= i + 3));
        chk("window.colB_lane", 64'(obs_col[t + 1][i] != '0), 64'(t >= i && t <= i + 3));
      end

    // A second start with different data during step 2 must be ignored.
    run(rand_mat(), rand_mat(), 2, "busy_start");
    repeat (3) begin
      @(posedge clk); #1;
      idle_chk("busy_start.after");
    end

    // Random matrices, back-to-back and with idle gaps.
    for (int r = 0; r < 6; r++) begin
      run(rand_mat(), rand_mat(), -1, "rand");
      gap = int'($urandom_range(0, 3));
      repeat (gap) begin
        @(posedge clk); #1;
        idle_chk("rand.gap");
      end
    end

    // Asynchronous reset while step 4 is on the outputs.
    a = rand_mat();
    b = rand_mat();
    bus.i_a = a;
    bus.i_b = b;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("rst.pre_valid", 64'(bus.o_feedValid), 64'd1);
    chk("rst.pre_rowA",  64'(bus.o_rowA), 64'(skew_a(a, 4)));
    #2;
    arst = 1'b1;
    #1;
    idle_chk("rst.async");
    @(posedge clk); #1;
    idle_chk("rst.held");
    arst = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      idle_chk("rst.after");
    end
    run(rand_mat(), rand_mat(), -1, "rst.fresh");

    // Start already high at the first edge after reset release.
    arst = 1'b1;
    @(posedge clk); #1;
    arst = 1'b0;
    run(rand_mat(), rand_mat(), -1, "rst.release_start");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
